// File: rtl/seq_pattern_gen.sv
// Serializes a latched pattern LSB first with done pulse; optional repetition
// with one gap cycle between passes when SEQ_PATTERN_GEN_REPEAT_EN is defined.
module seq_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int LENW  = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_pattern,
  input  logic [LENW-1:0]  i_len,
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  input  logic [3:0]       i_repeat,
`endif
  output logic             o_x,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_state
);

  // state | meaning
  // IDLE  | waiting for a start with a legal length
  // SHIFT | driving latched pattern bit idx_q on o_x
  // GAP   | one idle cycle between repetitions
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  idx_q;
  logic [LENW-1:0]  idx_nxt;
  logic             len_ok;
  logic             last_bit;
  logic             next_bit;
  logic             more_reps;

  assign len_ok   = (i_len != '0) && (i_len <= LENW'(WIDTH));
  assign last_bit = (idx_q == (len_q - LENW'(1)));
  assign idx_nxt  = idx_q + LENW'(1);
  // mask-and-reduce keeps the index within the pattern width
  assign next_bit = |(pat_q & (WIDTH'(1) << idx_nxt));

`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  logic [3:0] rep_q;
  assign more_reps = (rep_q != 4'd0);
`else
  assign more_reps = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      o_x     <= 1'b0;
      o_valid <= 1'b0;
      o_done  <= 1'b0;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
      rep_q   <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_start && len_ok) begin
            state   <= SHIFT;
            pat_q   <= i_pattern;
            len_q   <= i_len;
            idx_q   <= '0;
            o_x     <= i_pattern[0];
            o_valid <= 1'b1;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
            rep_q   <= i_repeat;
`endif
          end
        end
        SHIFT: begin
          if (last_bit) begin
            o_x     <= 1'b0;
            o_valid <= 1'b0;
            if (more_reps) begin
              state <= GAP;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
            end
          end else begin
            idx_q <= idx_nxt;
            o_x   <= next_bit;
          end
        end
        GAP: begin
          state   <= SHIFT;
          idx_q   <= '0;
          o_x     <= pat_q[0];
          o_valid <= 1'b1;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
          rep_q   <= rep_q - 4'd1;
`endif
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_x     <= 1'b0;
          o_valid <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_state = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized and directed bench for seq_pattern_gen against a frame-queue model.
module tb_seq_pattern_gen;
  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_pattern;
  logic [4:0]  i_len;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
  logic [3:0]  i_repeat;
`endif
  logic        o_x, o_valid, o_busy, o_done;
  logic [1:0]  o_state;

  int checks = 0;
  int failures = 0;

  logic [5:0] obs;
  logic [5:0] cur;
  logic [5:0] q[$];

  assign obs = {o_state, o_busy, o_done, o_valid, o_x};

  seq_pattern_gen #(.WIDTH(16), .LENW(5)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_start(i_start),
    .i_pattern(i_pattern),
    .i_len(i_len),
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    .i_repeat(i_repeat),
`endif
    .o_x(o_x),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame = {state, busy, done, valid, x}; a transfer is a precomputed list of frames.
  task automatic model_edge();
    int rep;
    rep = 0;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    rep = int'(i_repeat);
`endif
    if (cur == 6'b0 && i_start && i_len >= 1 && i_len <= 16) begin
      for (int r = 0; r <= rep; r++) begin
        for (int k = 0; k < int'(i_len); k++)
          q.push_back({2'b01, 1'b1, 1'b0, 1'b1, i_pattern[k]});
        if (r < rep) q.push_back({2'b10, 1'b1, 1'b0, 1'b0, 1'b0});
      end
      q.push_back({2'b11, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    cur = (q.size() > 0) ? q.pop_front() : 6'b0;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check(tag, 32'(obs), 32'(cur));
  endtask

  task automatic apply_reset(input string tag);
    i_rst = 1'b1;
    #1;
    q.delete();
    cur = 6'b0;
    check(tag, 32'(obs), 32'h0);
    @(posedge i_clk);
    #1;
    check(tag, 32'(obs), 32'h0);
    #2;
    i_rst = 1'b0;
  endtask

  task automatic start_xfer(input logic [15:0] pat, input logic [4:0] len, input logic [3:0] rep);
    i_pattern = pat;
    i_len     = len;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    i_repeat  = rep;
`else
    if (rep != 4'd0) $display("note: repeat ignored in this build");
`endif
    i_start   = 1'b1;
  endtask

  initial begin
    int done_cnt;
    logic [15:0] seq_got;
    i_rst = 1'b1; i_start = 1'b0; i_pattern = '0; i_len = '0;
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    i_repeat = '0;
`endif
    cur = 6'b0;
    #2;
    check("reset_state", 32'(obs), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // single pass, 4 ones
    start_xfer(16'h000F, 5'd4, 4'd0);
    tick("single_c1");
    i_start = 1'b0;
    for (int c = 2; c <= 6; c++) tick($sformatf("single_c%0d", c));
    check("single_idle", 32'(o_state), 32'h0);

    // full-width bit order
    start_xfer(16'hA5A5, 5'd16, 4'd0);
    seq_got = '0;
    for (int c = 1; c <= 16; c++) begin
      tick($sformatf("order_c%0d", c));
      i_start = 1'b0;
      seq_got[c-1] = o_x;
    end
    check("order_seq", 32'(seq_got), 32'hA5A5);
    tick("order_done");
    check("order_done_pulse", 32'(o_done), 32'h1);
    tick("order_idle");

    // illegal length ignored
    start_xfer(16'hFFFF, 5'd0, 4'd0);
    for (int c = 0; c < 3; c++) tick("len0");
    check("len0_busy", 32'(o_busy), 32'h0);
    i_len = 5'd17;
    tick("len17");
    check("len17_busy", 32'(o_busy), 32'h0);
    i_start = 1'b0;

    // second start while busy is ignored
    start_xfer(16'h0005, 5'd4, 4'd0);
    tick("busy_c1");
    i_start = 1'b0;
    tick("busy_c2");
    i_start = 1'b1; i_pattern = 16'hFFFF;
    tick("busy_c3");
    i_start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick("busy_tail");
      if (o_done) done_cnt++;
    end
    check("busy_one_done", 32'(done_cnt), 32'h1);

    // reset mid-transfer
    start_xfer(16'hFFFF, 5'd16, 4'd0);
    tick("mrst_c1");
    i_start = 1'b0;
    tick("mrst_c2");
    tick("mrst_c3");
    apply_reset("mrst_async");
    check("mrst_no_done", 32'(o_done), 32'h0);
    start_xfer(16'h0002, 5'd2, 4'd0);
    tick("after_rst_c1");
    i_start = 1'b0;
    for (int c = 2; c <= 4; c++) tick("after_rst");

    // input changes during transfer have no effect
    start_xfer(16'h0009, 5'd4, 4'd0);
    seq_got = '0;
    for (int c = 1; c <= 4; c++) begin
      tick("hold");
      i_start = 1'b0;
      i_pattern = 16'($urandom);
      i_len = 5'($urandom);
      seq_got[c-1] = o_x;
    end
    check("hold_seq", 32'(seq_got[3:0]), 32'h9);
    i_len = 5'd1;
    for (int c = 0; c < 2; c++) tick("hold_tail");

`ifdef SEQ_PATTERN_GEN_REPEAT_EN
    start_xfer(16'h0003, 5'd2, 4'd2);
    for (int c = 1; c <= 10; c++) begin
      tick($sformatf("rep_c%0d", c));
      i_start = 1'b0;
      if (c == 3 || c == 6) check("rep_gap_valid", 32'(o_valid), 32'h0);
      if (c == 9) check("rep_done", 32'(o_done), 32'h1);
    end
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      i_start   = ($urandom_range(0, 3) == 0);
      i_len     = 5'($urandom_range(0, 20));
      i_pattern = 16'($urandom);
`ifdef SEQ_PATTERN_GEN_REPEAT_EN
      i_repeat  = 4'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 299) == 0) apply_reset("rand_rst");
      else tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
